// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-to-AXI bridge: request type codes, AXI
// encodings and the read/write FSM state types.
package cache_axi_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_1B    = 3'd0;
  localparam logic [2:0] SIZE_2B    = 3'd1;
  localparam logic [2:0] SIZE_4B    = 3'd2;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;

  // Index of the final beat: a line is four 32-bit beats, everything else one.
  function automatic logic [1:0] last_beat(input logic [2:0] t);
    return (t == TYPE_LINE) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [7:0] axi_len(input logic [2:0] t);
    return {6'd0, last_beat(t)};
  endfunction

  function automatic logic [2:0] axi_size(input logic [2:0] t);
    case (t)
      TYPE_BYTE: return SIZE_1B;
      TYPE_HALF: return SIZE_2B;
      TYPE_WORD: return SIZE_4B;
      default:   return SIZE_4B;
    endcase
  endfunction

endpackage

// File: rtl/axi_wbeat_serializer.sv
// Latches a 128-bit write payload and presents it as up to four 32-bit AXI W
// beats, low word first, raising wlast on the final beat.
module axi_wbeat_serializer (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [127:0] load_data,
  input  logic [1:0]   load_last,
  input  logic [3:0]   load_strb,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready
);

  logic [127:0] data_reg;
  logic [1:0]   beat_reg;
  logic [1:0]   last_reg;
  logic [3:0]   strb_reg;
  logic         busy_reg;
  logic [31:0]  word [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign word[gi] = data_reg[32*gi +: 32];
    end
  endgenerate

  assign wdata  = word[beat_reg];
  assign wstrb  = strb_reg;
  assign wvalid = busy_reg;
  assign wlast  = busy_reg && (beat_reg == last_reg);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_reg <= '0;
      beat_reg <= '0;
      last_reg <= '0;
      strb_reg <= '0;
      busy_reg <= 1'b0;
    end else if (load) begin
      data_reg <= load_data;
      beat_reg <= '0;
      last_reg <= load_last;
      strb_reg <= load_strb;
      busy_reg <= 1'b1;
    end else if (busy_reg && wready) begin
      if (wlast) busy_reg <= 1'b0;
      else       beat_reg <= beat_reg + 2'd1;
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridges a simple cache read/write request port onto AXI4. Independent read
// and write FSMs; reads to a line with a write in flight are held off.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_e   rd_state_reg, rd_state_next;
  wr_state_e   wr_state_reg, wr_state_next;
  logic [31:0] rd_addr_reg, wr_addr_reg;
  logic [2:0]  rd_type_reg, wr_type_reg;
  logic        aw_done_reg;
  logic        rd_fire, wr_fire, line_hazard, aw_ok, w_ok, ser_wvalid;
  logic        unused_axi;

  // Responses carry no information the cache needs.
  assign unused_axi = ^{rid, rresp, bid, bresp};

  assign wr_rdy  = (wr_state_reg == W_IDLE);
  assign wr_fire = wr_req && wr_rdy;

  // Stall a read that targets the line of a pending write, including one
  // being accepted this very cycle.
  assign line_hazard = (!wr_rdy && (rd_addr[31:4] == wr_addr_reg[31:4])) ||
                       (wr_fire && (rd_addr[31:4] == wr_addr[31:4]));
  assign rd_rdy  = (rd_state_reg == R_IDLE) && !line_hazard;
  assign rd_fire = rd_req && rd_rdy;

  assign arid      = RD_ID;
  assign araddr    = rd_addr_reg;
  assign arlen     = axi_len(rd_type_reg);
  assign arsize    = axi_size(rd_type_reg);
  assign arburst   = BURST_INCR;
  assign arvalid   = resetn && (rd_state_reg == R_AR);
  assign rready    = resetn && (rd_state_reg == R_DATA);
  assign ret_valid = rready && rvalid;
  assign ret_last  = rready && rlast;
  assign ret_data  = rdata;

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (rd_fire) rd_state_next = R_AR;
      R_AR:    if (arready) rd_state_next = R_DATA;
      R_DATA:  if (rvalid && rlast) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_reg <= R_IDLE;
      rd_addr_reg  <= '0;
      rd_type_reg  <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (rd_fire) begin
        rd_addr_reg <= rd_addr;
        rd_type_reg <= rd_type;
      end
    end
  end

  axi_wbeat_serializer u_wbeat (
    .clk       (clk),
    .resetn    (resetn),
    .load      (wr_fire),
    .load_data (wr_data),
    .load_last (last_beat(wr_type)),
    .load_strb ((wr_type == TYPE_LINE) ? 4'hF : wr_wstrb),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (ser_wvalid),
    .wready    (wready)
  );

  assign wvalid  = resetn && ser_wvalid;
  assign awid    = WR_ID;
  assign awaddr  = wr_addr_reg;
  assign awlen   = axi_len(wr_type_reg);
  assign awsize  = axi_size(wr_type_reg);
  assign awburst = BURST_INCR;
  assign awvalid = resetn && (wr_state_reg == W_REQ) && !aw_done_reg;
  assign bready  = resetn && (wr_state_reg == W_RESP);

  // AW and W complete independently; leave W_REQ once both have finished.
  assign aw_ok = aw_done_reg || (awvalid && awready);
  assign w_ok  = !ser_wvalid || (wready && wlast);

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      W_IDLE:  if (wr_fire) wr_state_next = W_REQ;
      W_REQ:   if (aw_ok && w_ok) wr_state_next = W_RESP;
      W_RESP:  if (bvalid) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_reg <= W_IDLE;
      wr_addr_reg  <= '0;
      wr_type_reg  <= '0;
      aw_done_reg  <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      if (wr_fire) begin
        wr_addr_reg <= wr_addr;
        wr_type_reg <= wr_type;
        aw_done_reg <= 1'b0;
      end else if (awvalid && awready) begin
        aw_done_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Bench for cache_axi_bridge: table of read/write transactions against a
// scripted AXI slave, returned read data checked through a scoreboard queue.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 0, rd_rdy, ret_valid, ret_last;
  logic [2:0]   rd_type = 0;
  logic [31:0]  rd_addr = 0, ret_data;
  logic         wr_req = 0, wr_rdy;
  logic [2:0]   wr_type = 0;
  logic [31:0]  wr_addr = 0;
  logic [3:0]   wr_wstrb = 0;
  logic [127:0] wr_data = 0;
  logic [3:0]   arid, awid;
  logic [31:0]  araddr, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic         arvalid, arready = 0, rready, awvalid, awready = 0;
  logic [3:0]   rid = 0, bid = 0, wstrb;
  logic [31:0]  rdata = 0;
  logic [1:0]   rresp = 0, bresp = 0;
  logic         rlast = 0, rvalid = 0, wlast, wvalid, wready = 0;
  logic         bvalid = 0, bready;

  always #5 clk = ~clk;

  cache_axi_bridge #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q[$];
  logic [32:0] sb_exp;

  typedef struct {
    bit           is_wr;
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] data;
    int           addr_wait;
    int           data_wait;
    logic [7:0]   exp_len;
    logic [2:0]   exp_size;
    logic [3:0]   exp_strb;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every returned beat must match the oldest beat the slave drove.
  always @(negedge clk) begin
    if (ret_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ret_unexpected: got ret_valid=1 data=%h, expected no return", ret_data);
      end else begin
        sb_exp = sb_q.pop_front();
        check("ret_beat", {95'd0, ret_last, ret_data}, {95'd0, sb_exp});
      end
    end
  end

  task automatic send_beat(input logic last);
    logic [31:0] d;
    d = $urandom;
    rvalid = 1'b1;
    rdata = d;
    rlast = last;
    sb_q.push_back({last, d});
    @(negedge clk);
    check("rready", rready, 1);
    tick();
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  task automatic do_read(input vec_t v);
    int n;
    tick();
    rd_req = 1'b1; rd_addr = v.addr; rd_type = v.typ;
    @(negedge clk);
    check("rd_rdy_idle", rd_rdy, 1);
    tick();
    rd_req = 1'b0; rd_addr = 32'hDEAD_BEE0;
    for (int i = 0; i < v.addr_wait; i++) begin
      @(negedge clk);
      check("arvalid_wait", arvalid, 1);
      check("araddr_stable", araddr, v.addr);
      tick();
    end
    arready = 1'b1;
    @(negedge clk);
    check("arvalid", arvalid, 1);
    check("araddr", araddr, v.addr);
    check("arlen", arlen, v.exp_len);
    check("arsize", arsize, v.exp_size);
    check("arburst", arburst, 2'b01);
    check("arid", arid, 4'd0);
    tick();
    arready = 1'b0;
    n = int'(v.exp_len) + 1;
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        for (int g = 0; g < v.data_wait; g++) begin
          @(negedge clk);
          check("rready_gap", rready, 1);
          tick();
        end
      end
      send_beat(b == n - 1);
    end
    @(negedge clk);
    check("rd_rdy_done", rd_rdy, 1);
    check("rready_done", rready, 0);
    $display("read  addr=%h type=%b beats=%0d", v.addr, v.typ, n);
  endtask

  task automatic do_write(input vec_t v);
    tick();
    wr_req = 1'b1; wr_addr = v.addr; wr_type = v.typ; wr_wstrb = v.strb; wr_data = v.data;
    @(negedge clk);
    check("wr_rdy_idle", wr_rdy, 1);
    tick();
    wr_req = 1'b0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    fork
      begin
        for (int i = 0; i < v.addr_wait; i++) begin
          @(negedge clk);
          check("awvalid_wait", awvalid, 1);
          check("awaddr_stable", awaddr, v.addr);
          tick();
        end
        awready = 1'b1;
        @(negedge clk);
        check("awvalid", awvalid, 1);
        check("awaddr", awaddr, v.addr);
        check("awlen", awlen, v.exp_len);
        check("awsize", awsize, v.exp_size);
        check("awburst", awburst, 2'b01);
        check("awid", awid, 4'd1);
        tick();
        awready = 1'b0;
      end
      begin
        for (int i = 0; i < v.data_wait; i++) begin
          @(negedge clk);
          check("wvalid_wait", wvalid, 1);
          check("wdata_stable", wdata, v.data[31:0]);
          tick();
        end
        for (int b = 0; b <= int'(v.exp_len); b++) begin
          wready = 1'b1;
          @(negedge clk);
          check("wvalid", wvalid, 1);
          check("wdata", wdata, v.data[32*b +: 32]);
          check("wstrb", wstrb, v.exp_strb);
          check("wlast", wlast, b == int'(v.exp_len));
          tick();
          wready = 1'b0;
        end
      end
    join
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bready_wait", bready, 1);
      check("wvalid_after", wvalid, 0);
      tick();
    end
    bvalid = 1'b1; bid = 4'd1;
    @(negedge clk);
    check("bready", bready, 1);
    tick();
    bvalid = 1'b0;
    @(negedge clk);
    check("wr_rdy_done", wr_rdy, 1);
    $display("write addr=%h type=%b beats=%0d", v.addr, v.typ, int'(v.exp_len) + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //           wr    type    addr          strb   data                                         aw/ar wt  w/gap len    size  exp strb
    vecs[0] = '{1'b0, 3'b100, 32'h1C000040, 4'h0, 128'h0,                                      2, 0, 8'd3, 3'd2, 4'h0};
    vecs[1] = '{1'b1, 3'b100, 32'h00000100, 4'h3, 128'h44444444_33333333_22222222_11111111,  0, 3, 8'd3, 3'd2, 4'hF};
    vecs[2] = '{1'b1, 3'b010, 32'h00000204, 4'h6, 128'h0000_0000_0000_0000_0000_0000_CAFE_BABE, 3, 0, 8'd0, 3'd2, 4'h6};
    vecs[3] = '{1'b0, 3'b100, 32'h80001230, 4'h0, 128'h0,                                      5, 2, 8'd3, 3'd2, 4'h0};
    vecs[4] = '{1'b0, 3'b001, 32'h00000302, 4'h0, 128'h0,                                      1, 0, 8'd0, 3'd1, 4'h0};
    vecs[5] = '{1'b1, 3'b000, 32'h00000403, 4'h1, 128'h0000_0000_0000_0000_0000_0000_0000_00A5, 1, 1, 8'd0, 3'd0, 4'h1};
    vecs[6] = '{1'b1, 3'b001, 32'h00000506, 4'hC, 128'h0000_0000_0000_0000_0000_0000_BEEF_0000, 0, 0, 8'd0, 3'd1, 4'hC};
    vecs[7] = '{1'b0, 3'b000, 32'h00000607, 4'h0, 128'h0,                                      0, 0, 8'd0, 3'd0, 4'h0};

    repeat (3) tick();
    resetn = 1'b1;
    @(negedge clk);
    check("rst_rd_rdy", rd_rdy, 1);
    check("rst_wr_rdy", wr_rdy, 1);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, ret_valid, ret_last}, 7'd0);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i]);
      else               do_read(vecs[i]);
    end

    // Same-cycle read and write to one line: write wins, read waits for B.
    tick();
    wr_req = 1'b1; wr_addr = 32'h00001000; wr_type = 3'b010; wr_wstrb = 4'hF;
    wr_data = 128'h0000_0000_0000_0000_0000_0000_1234_5678;
    rd_req = 1'b1; rd_addr = 32'h0000100C; rd_type = 3'b010;
    @(negedge clk);
    check("hz_wr_rdy", wr_rdy, 1);
    check("hz_rd_rdy_same_cycle", rd_rdy, 0);
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hz_rd_rdy_req", rd_rdy, 0);
      check("hz_arvalid", arvalid, 0);
      tick();
    end
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    check("hz_wdata", wdata, 32'h12345678);
    tick();
    awready = 1'b0; wready = 1'b0;
    @(negedge clk);
    check("hz_rd_rdy_resp", rd_rdy, 0);
    check("hz_bready", bready, 1);
    tick();
    bvalid = 1'b1;
    @(negedge clk);
    check("hz_rd_rdy_bvalid", rd_rdy, 0);
    tick();
    bvalid = 1'b0;
    @(negedge clk);
    check("hz_rd_rdy_after_b", rd_rdy, 1);
    tick();
    rd_req = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    check("hz_araddr", araddr, 32'h0000100C);
    tick();
    arready = 1'b0;
    send_beat(1'b1);
    $display("hazard same line: read held until write response");

    // A read to a different line proceeds while the write is outstanding.
    wr_req = 1'b1; wr_addr = 32'h00001000;
    tick();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h00002000; rd_type = 3'b010;
    @(negedge clk);
    check("hz_rd_rdy_diff_line", rd_rdy, 1);
    tick();
    rd_req = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    check("hz_diff_araddr", araddr, 32'h00002000);
    check("hz_diff_awvalid", awvalid, 1);
    tick();
    arready = 1'b0;
    send_beat(1'b1);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    @(negedge clk);
    check("hz_diff_wr_rdy", wr_rdy, 1);
    $display("hazard other line: read accepted during write");

    // Reset in the middle of a line read after two beats.
    tick();
    rd_req = 1'b1; rd_addr = 32'h00003000; rd_type = 3'b100;
    tick();
    rd_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    send_beat(1'b0);
    send_beat(1'b0);
    resetn = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_arvalid", arvalid, 0);
    check("rst_mid_rready", rready, 0);
    check("rst_mid_ret_valid", ret_valid, 0);
    check("rst_mid_rd_rdy", rd_rdy, 1);
    check("rst_mid_wr_rdy", wr_rdy, 1);
    resetn = 1'b1;
    tick();
    rvalid = 1'b1; rdata = 32'hFFFF_0000; rlast = 1'b1;
    @(negedge clk);
    check("rst_stale_ret_valid", ret_valid, 0);
    check("rst_stale_rready", rready, 0);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    $display("reset during read data: transfer abandoned");

    @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
